// File: rtl/ibex_crc32_iter.sv
// Iterative reflected CRC32 / CRC32C unit for the RV32B ALU_CRC32{,C}_{B,H,W} operators.
// Runs BitsPerCycle chained CRC steps per BUSY cycle and returns rd over a valid/ready handshake.
module ibex_crc32_iter #(
    parameter int unsigned BitsPerCycle = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [6:0]  operator_i,
    input  logic [31:0] operand_a_i,
    output logic        ready_o,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    localparam int unsigned CntW = $clog2(32 / BitsPerCycle) + 1;

    // Operator encodings matching ibex_pkg::alu_op_e
    localparam logic [6:0] ALU_CRC32_B  = 7'd59;
    localparam logic [6:0] ALU_CRC32C_B = 7'd60;
    localparam logic [6:0] ALU_CRC32_H  = 7'd61;
    localparam logic [6:0] ALU_CRC32C_H = 7'd62;
    localparam logic [6:0] ALU_CRC32_W  = 7'd63;
    localparam logic [6:0] ALU_CRC32C_W = 7'd64;

    localparam logic [31:0] PolyCrc32  = 32'hEDB88320;
    localparam logic [31:0] PolyCrc32c = 32'h82F63B78;

    if (BitsPerCycle != 1 && BitsPerCycle != 2 && BitsPerCycle != 4 && BitsPerCycle != 8) begin : g_bad_param
        $error("ibex_crc32_iter: BitsPerCycle must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state;
    logic [31:0]     x;
    logic [31:0]     poly;
    logic [CntW-1:0] cnt;

    logic            is_crc;
    logic            use_crc32c;
    logic [5:0]      n_steps;
    logic [CntW-1:0] cnt_load;
    logic [31:0]     x_next;

    // Operator decode: CRC flavour and total step count
    always_comb begin
        is_crc     = 1'b0;
        use_crc32c = 1'b0;
        n_steps    = 6'd0;
        unique case (operator_i)
            ALU_CRC32_B:  begin is_crc = 1'b1; n_steps = 6'd8;  end
            ALU_CRC32C_B: begin is_crc = 1'b1; n_steps = 6'd8;  use_crc32c = 1'b1; end
            ALU_CRC32_H:  begin is_crc = 1'b1; n_steps = 6'd16; end
            ALU_CRC32C_H: begin is_crc = 1'b1; n_steps = 6'd16; use_crc32c = 1'b1; end
            ALU_CRC32_W:  begin is_crc = 1'b1; n_steps = 6'd32; end
            ALU_CRC32C_W: begin is_crc = 1'b1; n_steps = 6'd32; use_crc32c = 1'b1; end
            default:      ;
        endcase
    end

    assign cnt_load = CntW'(32'(n_steps) / BitsPerCycle);

    // One BUSY cycle worth of chained reflected-CRC steps
    always_comb begin
        x_next = x;
        for (int unsigned i = 0; i < BitsPerCycle; i++) begin
            x_next = (x_next >> 1) ^ (poly & {32{x_next[0]}});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= 32'h0;
            cnt      <= '0;
            x        <= 32'h0;
            poly     <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    // kill_i blocks a coincident request
                    if (valid_i && is_crc && !kill_i) begin
                        x       <= operand_a_i;
                        poly    <= use_crc32c ? PolyCrc32c : PolyCrc32;
                        cnt     <= cnt_load;
                        state   <= BUSY;
                        ready_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (kill_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        x   <= x_next;
                        cnt <= cnt - CntW'(1);
                        if (cnt == CntW'(1)) begin
                            state    <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= x_next;
                        end
                    end
                end
                DONE: begin
                    if (kill_i || ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_crc32_iter.sv
// Directed bench for ibex_crc32_iter: vector table at BitsPerCycle=8 plus handshake corner cases,
// and a second instance at BitsPerCycle=1 for the 32-cycle word latency.
module tb_ibex_crc32_iter;

    localparam logic [6:0] ALU_ADD      = 7'd0;
    localparam logic [6:0] ALU_CRC32_B  = 7'd59;
    localparam logic [6:0] ALU_CRC32C_B = 7'd60;
    localparam logic [6:0] ALU_CRC32_H  = 7'd61;
    localparam logic [6:0] ALU_CRC32C_H = 7'd62;
    localparam logic [6:0] ALU_CRC32_W  = 7'd63;
    localparam logic [6:0] ALU_CRC32C_W = 7'd64;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, kill, ready_in;
    logic [6:0]  op;
    logic [31:0] a;
    logic        ready_out, valid_out;
    logic [31:0] result;

    logic        valid1;
    logic [6:0]  op1;
    logic [31:0] a1;
    logic        ready_out1, valid_out1;
    logic [31:0] result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_crc32_iter #(.BitsPerCycle(8)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .operator_i(op), .operand_a_i(a),
        .ready_o(ready_out), .kill_i(kill), .valid_o(valid_out), .ready_i(ready_in),
        .result_o(result)
    );

    ibex_crc32_iter #(.BitsPerCycle(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid1), .operator_i(op1), .operand_a_i(a1),
        .ready_o(ready_out1), .kill_i(kill), .valid_o(valid_out1), .ready_i(ready_in),
        .result_o(result1)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request to the BitsPerCycle=8 instance; returns just after the accept edge
    task automatic start8(input logic [6:0] o, input logic [31:0] v);
        @(negedge clk);
        valid_in = 1'b1;
        op       = o;
        a        = v;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_valid8(output int cyc);
        cyc = 0;
        while (!valid_out && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int seen;
        logic [31:0] held;

        vecs[0] = '{"crc32_b_80",   ALU_CRC32_B,  32'h00000080, 32'hEDB88320, 1};
        vecs[1] = '{"crc32c_h_8000", ALU_CRC32C_H, 32'h00008000, 32'h82F63B78, 2};
        vecs[2] = '{"crc32c_b_0",   ALU_CRC32C_B, 32'h00000000, 32'h00000000, 1};
        vecs[3] = '{"crc32_b_100",  ALU_CRC32_B,  32'h00000100, 32'h00000001, 1};
        vecs[4] = '{"crc32_h_10000", ALU_CRC32_H, 32'h00010000, 32'h00000001, 2};
        vecs[5] = '{"crc32_b_40",   ALU_CRC32_B,  32'h00000040, 32'h76DC4190, 1};
        vecs[6] = '{"crc32c_b_40",  ALU_CRC32C_B, 32'h00000040, 32'h417B1DBC, 1};
        vecs[7] = '{"crc32c_w_8e7", ALU_CRC32C_W, 32'h80000000, 32'h82F63B78, 4};

        rst = 1'b1; valid_in = 1'b0; kill = 1'b0; ready_in = 1'b1; op = ALU_ADD; a = 32'h0;
        valid1 = 1'b0; op1 = ALU_ADD; a1 = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", 32'(ready_out), 32'h1);
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_result", result, 32'h0);

        // Table: every request completes with ready_i held high
        for (int i = 0; i < 8; i++) begin
            start8(vecs[i].op, vecs[i].a);
            chk({vecs[i].name, "_busy_ready"}, 32'(ready_out), 32'h0);
            wait_valid8(cyc);
            chk({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].lat));
            chk({vecs[i].name, "_result"}, result, vecs[i].exp);
            @(posedge clk); #1;
            chk({vecs[i].name, "_valid_drop"}, 32'(valid_out), 32'h0);
            chk({vecs[i].name, "_ready_back"}, 32'(ready_out), 32'h1);
        end

        // Reset in the middle of a word operation
        start8(ALU_CRC32_W, 32'h80000000);
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy_ready", 32'(ready_out), 32'h1);
        chk("rst_busy_valid", 32'(valid_out), 32'h0);
        chk("rst_busy_result", result, 32'h0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("rst_busy_no_valid", 32'(seen), 32'h0);

        // Back-pressure in DONE for 5 cycles
        ready_in = 1'b0;
        start8(ALU_CRC32_B, 32'h00000080);
        wait_valid8(cyc);
        chk("bp_result", result, 32'hEDB88320);
        held = result;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(valid_out), 32'h1);
            chk("bp_result_stable", result, held);
            chk("bp_ready", 32'(ready_out), 32'h0);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(valid_out), 32'h0);
        chk("bp_release_ready", 32'(ready_out), 32'h1);

        // Kill while BUSY
        start8(ALU_CRC32_W, 32'h80000000);
        @(negedge clk) kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy_ready", 32'(ready_out), 32'h1);
        chk("kill_busy_valid", 32'(valid_out), 32'h0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("kill_busy_no_valid", 32'(seen), 32'h0);

        // Kill while DONE
        ready_in = 1'b0;
        start8(ALU_CRC32C_B, 32'h00000040);
        wait_valid8(cyc);
        chk("kill_done_reached", 32'(valid_out), 32'h1);
        @(negedge clk) kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        ready_in = 1'b1;
        chk("kill_done_valid", 32'(valid_out), 32'h0);
        chk("kill_done_ready", 32'(ready_out), 32'h1);

        // Non-CRC operator is ignored
        start8(ALU_ADD, 32'h00000080);
        chk("add_ignored_ready", 32'(ready_out), 32'h1);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("add_no_valid", 32'(seen), 32'h0);

        // kill_i wins over a coincident CRC request in IDLE
        @(negedge clk);
        valid_in = 1'b1; op = ALU_CRC32_B; a = 32'h00000080; kill = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; kill = 1'b0;
        chk("kill_idle_ready", 32'(ready_out), 32'h1);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("kill_idle_no_valid", 32'(seen), 32'h0);

        // BitsPerCycle=1: word takes exactly 32 BUSY cycles
        @(negedge clk);
        valid1 = 1'b1; op1 = ALU_CRC32_W; a1 = 32'h80000000;
        @(posedge clk); #1;
        valid1 = 1'b0;
        chk("bpc1_busy_ready", 32'(ready_out1), 32'h0);
        cyc = 0;
        while (!valid_out1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bpc1_latency", 32'(cyc), 32'd32);
        chk("bpc1_result", result1, 32'hEDB88320);
        @(posedge clk); #1;
        chk("bpc1_valid_drop", 32'(valid_out1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
